// File: rtl/uart_tx_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo_reader
//  Purpose  : Drains bytes from an upstream FIFO and transmits each one as an
//             8N1 UART frame (start bit, 8 data bits LSB first, stop bit).
//             Timing uses a clock divider producing 16 ticks per bit, so
//             every bit lasts 16*DIV clocks, with DIV = CLK_FREQ/(BAUD*16).
//             DIV must be at least 1.
//
//  Ports    : clk        - system clock, rising-edge active
//             rst        - asynchronous active-high reset
//             fifo_data  - byte at the upstream FIFO read pointer
//             fifo_empty - upstream FIFO empty flag (registered upstream)
//             fifo_pop   - one-cycle pop strobe to the upstream FIFO
//             tx         - serial output, idle high
//             tx_busy    - high while a frame is in progress
//
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo_reader #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_pop,
    output logic       tx,
    output logic       tx_busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_div   = CLK_FREQ / (BAUD * 16);
    localparam int c_div_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_div_w-1:0] r_div_cnt;
    logic [3:0]         r_tick_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;

    logic w_tick;
    logic w_bit_done;
    logic w_accept;

    // The divider sits at 0 in IDLE; with DIV=1 its terminal count equals 0,
    // so the tick must also be qualified by being outside IDLE.
    assign w_tick     = (r_state != c_st_idle) && (r_div_cnt == c_div_last);
    assign w_bit_done = w_tick && (r_tick_cnt == 4'd15);
    // A byte is taken in the same cycle the FSM sees it waiting in IDLE.
    assign w_accept   = (r_state == c_st_idle) && !fifo_empty;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (w_accept)                        w_next_state = c_st_start;
            c_st_start: if (w_bit_done)                      w_next_state = c_st_data;
            c_st_data:  if (w_bit_done && r_bit_idx == 3'd7) w_next_state = c_st_stop;
            c_st_stop:  if (w_bit_done)                      w_next_state = c_st_idle;
            default:                                         w_next_state = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // Outputs depend only on FSM state, the latched byte and the registered
    // upstream empty flag; fifo_data never reaches tx combinationally.
    // ------------------------------------------------------------------------
    always_comb begin
        fifo_pop = 1'b0;
        tx       = 1'b1;
        tx_busy  = 1'b0;
        case (r_state)
            c_st_idle: begin
                // rst gating keeps a non-empty FIFO from being popped while
                // the block is held in reset.
                fifo_pop = !fifo_empty && !rst;
            end
            c_st_start: begin
                tx      = 1'b0;
                tx_busy = 1'b1;
            end
            c_st_data: begin
                tx      = r_shift[r_bit_idx];
                tx_busy = 1'b1;
            end
            c_st_stop: begin
                tx      = 1'b1;
                tx_busy = 1'b1;
            end
            default: begin
                fifo_pop = 1'b0;
                tx       = 1'b1;
                tx_busy  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Baud divider, tick counter, bit index and shift register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
        end else begin
            // Divider: held at 0 in IDLE so the first START cycle always
            // begins a full bit period.
            if (r_state == c_st_idle || r_div_cnt == c_div_last) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            // Tick counter wraps 15 -> 0 at each bit boundary on its own.
            if (r_state == c_st_idle) begin
                r_tick_cnt <= 4'd0;
            end else if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end

            // Bit index wraps 7 -> 0 when the last data bit completes.
            if (r_state != c_st_data) begin
                r_bit_idx <= 3'd0;
            end else if (w_bit_done) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            // Byte is captured only in the pop cycle; later upstream changes
            // cannot disturb the frame in flight.
            if (w_accept) begin
                r_shift <= fifo_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo_reader
//  Purpose  : Self-checking bench for uart_tx_fifo_reader. Instance A runs
//             with DIV=1 and is fed by a queue-based FIFO model; every byte
//             pushed is also pushed to an expected-byte scoreboard, and a
//             frame monitor decodes tx and compares against it. Instance B
//             runs with DIV=3 to exercise the divider.
//  Revision : 1.0  initial release
// ============================================================================
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            failures++; \
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp); \
        end \
    end

module tb_uart_tx_fifo_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] fifo_data_a, fifo_data_b;
    logic       fifo_empty_a, fifo_empty_b;
    logic       fifo_pop_a, fifo_pop_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q_a[$];      // FIFO model contents for instance A
    logic [7:0] exp_q[$];    // scoreboard of bytes expected on tx_a
    int         gaps_a[$];   // idle clocks seen before each frame start

    int  pops_a = 0, pops_b = 0;
    int  frames_started = 0, frames_done = 0, frames_aborted = 0;
    int  idle_a = 0;
    logic prev_tx_a = 1'b1;
    logic pop_pending_a = 1'b0;
    time  last_pop_a = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_reader #(.CLK_FREQ(1_600_000), .BAUD(100_000)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data_a),
        .fifo_empty (fifo_empty_a),
        .fifo_pop   (fifo_pop_a),
        .tx         (tx_a),
        .tx_busy    (busy_a)
    );

    uart_tx_fifo_reader #(.CLK_FREQ(4_800_000), .BAUD(100_000)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data_b),
        .fifo_empty (fifo_empty_b),
        .fifo_pop   (fifo_pop_b),
        .tx         (tx_b),
        .tx_busy    (busy_b)
    );

    // Pop observer: samples strobes mid-cycle.
    always @(negedge clk) begin
        pop_pending_a = fifo_pop_a;
        if (fifo_pop_a === 1'b1) begin
            pops_a++;
            last_pop_a = $time;
            `CHK("pop_a_while_empty", fifo_empty_a, 1'b0)
        end
        if (fifo_pop_b === 1'b1) begin
            pops_b++;
            `CHK("pop_b_while_empty", fifo_empty_b, 1'b0)
        end
    end

    // FIFO model for A: registered empty flag and head-of-queue data.
    always @(posedge clk) begin
        #1;
        if (pop_pending_a && q_a.size() > 0) void'(q_a.pop_front());
        fifo_empty_a = (q_a.size() == 0);
        fifo_data_a  = fifo_empty_a ? 8'h00 : q_a[0];
    end

    // Frame monitor for A: decodes each frame and checks it against the
    // scoreboard (each bit must be held exactly 16 clocks at DIV=1).
    always begin : mon_a
        logic [9:0] fb;
        logic [7:0] eb;
        int         good;
        bit         aborted;
        @(negedge clk);
        if (rst === 1'b1) begin
            prev_tx_a = 1'b1;
            idle_a    = 0;
        end else if (tx_a === 1'b0 && prev_tx_a === 1'b1) begin
            gaps_a.push_back(idle_a);
            idle_a = 0;
            frames_started++;
            `CHK("pop_to_start_a", $time - last_pop_a, 64'd10)
            `CHK("frame_expected_a", exp_q.size() > 0, 1'b1)
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            fb = {1'b1, eb, 1'b0};
            aborted = 1'b0;
            for (int b = 0; b < 10 && !aborted; b++) begin
                good = 0;
                for (int c = 0; c < 16; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx_a === fb[b] && busy_a === 1'b1) good++;
                end
                if (!aborted) `CHK("frame_bit_a", good, 16)
            end
            if (!aborted) begin
                @(negedge clk);
                `CHK("frame_end_idle_a", {busy_a, tx_a}, 2'b01)
                frames_done++;
                prev_tx_a = tx_a;
                idle_a    = (busy_a === 1'b0) ? 1 : 0;
            end else begin
                frames_aborted++;
                prev_tx_a = 1'b1;
                idle_a    = 0;
            end
        end else begin
            if (busy_a === 1'b0) idle_a++;
            prev_tx_a = tx_a;
        end
    end

    task automatic push_a(input logic [7:0] b);
        q_a.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (frames_done < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin : main
        int         bad;
        int         mism;
        int         t;
        logic [9:0] fbb;

        rst          = 1'b1;
        fifo_empty_a = 1'b1;
        fifo_data_a  = 8'h00;
        fifo_empty_b = 1'b1;
        fifo_data_b  = 8'h00;
        repeat (3) @(negedge clk);
        `CHK("reset_tx_a", tx_a, 1'b1)
        `CHK("reset_busy_a", busy_a, 1'b0)
        `CHK("reset_pop_a", fifo_pop_a, 1'b0)
        `CHK("reset_tx_b", tx_b, 1'b1)
        `CHK("reset_busy_b", busy_b, 1'b0)
        @(posedge clk); #1 rst = 1'b0;

        // Empty FIFO for 1000 clocks: line stays idle, never pops.
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || fifo_pop_a !== 1'b0) bad++;
        end
        `CHK("idle_1000_a", bad, 0)
        `CHK("idle_pops_a", pops_a, 0)

        // Single byte 0xA5.
        push_a(8'hA5);
        wait_done(1);
        `CHK("frames_after_A5", frames_done, 1)
        `CHK("pops_after_A5", pops_a, 1)

        // Back-to-back 0x00, 0xFF, 0x3C.
        push_a(8'h00);
        push_a(8'hFF);
        push_a(8'h3C);
        wait_done(4);
        `CHK("frames_after_3", frames_done, 4)
        `CHK("pops_after_3", pops_a, 4)
        `CHK("gap_frame3", gaps_a[2], 1)
        `CHK("gap_frame4", gaps_a[3], 1)

        // 0x81; model presents 0x00 right after the pop.
        push_a(8'h81);
        wait_done(5);
        `CHK("frames_after_81", frames_done, 5)
        `CHK("pops_after_81", pops_a, 5)

        // Reset during data bit 3 of 0xC3, with 0x5A waiting in the FIFO.
        push_a(8'hC3);
        t = 0;
        while (frames_started < 6 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        `CHK("start_C3", frames_started, 6)
        repeat (72) @(negedge clk);
        #2;
        push_a(8'h5A);
        rst = 1'b1;
        #1;
        `CHK("midreset_tx_a", tx_a, 1'b1)
        `CHK("midreset_busy_a", busy_a, 1'b0)
        `CHK("midreset_pop_a", fifo_pop_a, 1'b0)
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (fifo_pop_a !== 1'b0 || tx_a !== 1'b1) bad++;
        end
        `CHK("pop_during_reset_a", bad, 0)
        @(posedge clk); #1 rst = 1'b0;
        wait_done(6);
        `CHK("frames_after_reset", frames_done, 6)
        `CHK("frames_aborted", frames_aborted, 1)
        `CHK("pops_after_reset", pops_a, 7)
        `CHK("scoreboard_drained", exp_q.size(), 0)

        // Instance B (DIV=3): 0xA5, every bit 48 clocks, frame 480 clocks.
        fbb = {1'b1, 8'hA5, 1'b0};
        @(posedge clk); #1;
        fifo_data_b  = 8'hA5;
        fifo_empty_b = 1'b0;
        #1;
        `CHK("pop_b_asserted", fifo_pop_b, 1'b1)
        @(posedge clk); #1;
        fifo_empty_b = 1'b1;
        fifo_data_b  = 8'h00;
        `CHK("busy_b_start", busy_b, 1'b1)
        `CHK("pop_b_single", fifo_pop_b, 1'b0)
        mism = 0;
        for (int c = 0; c < 480; c++) begin
            @(negedge clk);
            if (tx_b !== fbb[c / 48] || busy_b !== 1'b1) mism++;
        end
        `CHK("frame_b_bits", mism, 0)
        @(negedge clk);
        `CHK("frame_b_end", {busy_b, tx_b}, 2'b01)
        `CHK("pops_b", pops_b, 1)

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`undef CHK
`default_nettype wire

// File: doc/uart_tx_fifo_reader.md
UART_TX_FIFO_READER -- requirements
Module: uart_tx_fifo_reader

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003 Derived constant DIV = CLK_FREQ/(BAUD*16), integer division truncated; DIV SHALL be >= 1.
REQ-004 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous and active-high.
REQ-006 Port fifo_data  input  8  byte at the upstream FIFO read pointer; valid whenever fifo_empty=0.
REQ-007 Port fifo_empty  input  1  upstream FIFO empty flag, registered upstream.
REQ-008 Port fifo_pop  output  1  one-cycle pop strobe to the upstream FIFO.
REQ-009 Port tx  output  1  serial line, idle high, 8N1 framing, LSB first.
REQ-010 Port tx_busy  output  1  high while a frame is in progress.

Function
REQ-011 Internal tick divider SHALL count 0..DIV-1 and pulse a tick for one clock at count DIV-1; it SHALL be held at 0 in IDLE.
REQ-012 Internal tick counter SHALL count ticks 0..15 per bit; each bit SHALL last exactly 16*DIV clocks.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: tx=1, tx_busy=0, fifo_pop=0 unless a byte is being accepted.
REQ-015 IDLE with fifo_empty=0: in the same cycle, assert fifo_pop for exactly one clock, latch fifo_data into the shift register, and go to START on the next edge.
REQ-016 No more than one fifo_pop SHALL occur per frame; fifo_pop SHALL never assert while fifo_empty=1.
REQ-017 START: tx=0 for 16 ticks, then DATA with bit index 0.
REQ-018 DATA: tx = shift register bit[index], index 0..7; after 16 ticks of bit 7, go to STOP.
REQ-019 STOP: tx=1 for 16 ticks, then IDLE.
REQ-020 tx_busy SHALL be 1 in START, DATA, STOP.
REQ-021 First START cycle follows the pop cycle by exactly one clock; frame length is 160*DIV clocks from first START cycle to return to IDLE.
REQ-022 Back-to-back: if fifo_empty=0 on the first IDLE cycle after STOP, the next pop SHALL occur in that cycle, giving one idle-high clock between stop bit and next start bit.
REQ-023 The latched byte SHALL be unaffected by changes of fifo_data or fifo_empty after the pop cycle.
REQ-024 tx, fifo_pop, tx_busy SHALL be driven from registers or FSM state only, with no combinational path from fifo_data to tx.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, tx=1, tx_busy=0, fifo_pop=0, all counters and shift register 0.
REQ-026 Reset mid-frame SHALL abort the frame (byte discarded, no further pop); after release, operation SHALL resume from IDLE on the next edge.

Verification
REQ-027 Reset, fifo_empty=1 for 1000 clocks -> tx=1, tx_busy=0, fifo_pop never asserted.
REQ-028 CLK_FREQ=1_600_000, BAUD=100_000 (DIV=1); present 0xA5 with fifo_empty=0 -> one-cycle fifo_pop; tx = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each held 16 clocks; tx_busy high 160 clocks.
REQ-029 Same parameters, FIFO model holding 0x00, 0xFF, 0x3C -> exactly three pops, three frames decoded correctly, one idle clock between consecutive frames.
REQ-030 Change fifo_data to 0x00 the cycle after popping 0x81 -> frame still carries 0x81.
REQ-031 Assert rst during DATA bit 3 -> tx=1 and tx_busy=0 within the same cycle; no pop during reset; after release with fifo_empty=0, a new full frame starts.
REQ-032 Default parameters (DIV=651), send 0x55 -> every bit 10416 clocks, frame 104160 clocks.
